seq_det_prog: RTL and testbench
===============================

# seq_det_prog

Programmable serial-bit sequence detector, the parametrised successor to our fixed two-pattern detector. One bit of B is accepted per enabled clock and compared against a run-time loaded pattern of 1..PAT_W bits. A registered one-cycle match pulse w is produced, with selectable overlapping or non-overlapping detection. A saturating match counter is provided for status readback. Sits between the serial input front end and the control logic that consumes w.

## Interface
- PAT_W, 8: maximum pattern length in bits (>= 2).
- CNT_W, 8: match counter width (>= 1).
- LEN_W, $clog2(PAT_W+1): derived, width of Len.
- Clk  in  1  sole clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Load  in  1  capture Pat, Len and Overlap; restart detection.
- Pat  in  PAT_W  pattern; Pat[Len-1] is the first (oldest) bit, Pat[0] is the last.
- Len  in  LEN_W  pattern length; valid range 1..PAT_W.
- Overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- En  in  1  bit-accept strobe; B is sampled only when En=1.
- B  in  1  serial data bit.
- w  out  1  registered match pulse.
- Count  out  CNT_W  saturating number of matches since reset or last Load.
- Armed  out  1  high when a valid pattern is loaded (state != IDLE).

## Operation
- Internal registers:
  - PatR, LenR, OvlR: captured on Load.
  - H: PAT_W-bit history.
  - F: fill counter, LEN_W bits.
  - State: IDLE / FILL / HUNT.
- IDLE: reset state. En and B are ignored; w stays 0.
- Load, any state:
  - captures the configuration;
  - clears H, F and Count;
  - goes to IDLE if Len==0 or Len>PAT_W;
  - otherwise goes to HUNT if Len==1, else FILL.
  - Load has priority over En: the B value in a Load cycle is discarded, and w=0 in the following cycle.
- Accepted bit (En=1, no Load, State != IDLE): H <= {H[PAT_W-2:0], B}. Window = low LenR bits of the new H.
- FILL: F increments per accepted bit. When F reaches LenR-1, go to HUNT; no compare occurs in FILL.
- HUNT: every accepted bit is compared; match = (window == PatR[LenR-1:0]).
- On a match:
  - w=1 and Count increments, saturating at all-ones.
  - OvlR=1: stay in HUNT.
  - OvlR=0: clear F and H. Go to FILL if LenR>1, else stay in HUNT.
- En=0: H, F and State hold; w=0.

## Timing
- Reset values: w=0, Count=0, Armed=0, State=IDLE, H=0, F=0, PatR=0, LenR=0, OvlR=0.
- Latency: w is high for exactly the one cycle after the edge that accepts the final bit of a match. This is one cycle earlier than the fixed detector.
- Count updates on the same edge that sets w.
- Back-to-back matches, overlap mode: w can be high on consecutive cycles.
- Rst asserted mid-operation clears everything immediately, independent of Clk. The first edge after release behaves as IDLE.
- Count wrap-around: none. Count holds at 2^CNT_W-1; w still pulses.

## Structure
- Package seq_det_pkg holds the state enum (IDLE=0, FILL=1, HUNT=2) and a localparam for the state register width (2).
- Sub-module sat_cnt (parameter W; ports Clk, Rst, Clr, Inc, Q) implements the saturating counter.
- Everything else lives in one always block for state, F and H, plus the comparator.

## Test plan
- Reset, then Load Pat=3'b110, Len=3, Overlap=0; accept B = 1,1,1,0 -> w pulses once, the cycle after the 0 is accepted; Count=1.
- Load Pat=3'b101, Len=3; stream 1,0,1,0,1:
  - Overlap=1 -> two w pulses, Count=2;
  - Overlap=0 -> one w pulse, Count=1.
- PAT_W=8, Pat=8'hA5, Len=8; stream 0xA5 MSB-first, with En deasserted for 3 cycles mid-stream -> exactly one w pulse, after the 8th accepted bit.
- Load Len=0, then Len=9 -> Armed=0, w never asserts. Load issued mid-match (2 of 3 bits in) -> no w; a fresh full pattern is required afterwards.
- CNT_W=2, Len=1, Pat=1, Overlap=1; stream 5 ones -> w high 5 consecutive cycles, Count saturates at 3.
- Assert Rst asynchronously (between edges) during HUNT -> w, Count and Armed go to 0 before the next edge.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the programmable sequence detector.
//   STATE_W - width of the detector state register
//   state_e - detector state encoding (IDLE / FILL / HUNT)
package seq_det_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,  // no valid pattern loaded, input ignored
    FILL = 2'd1,  // collecting the first Len-1 bits, no compare yet
    HUNT = 2'd2   // every accepted bit completes a window to compare
  } state_e;

endpackage : seq_det_pkg

// File: rtl/sat_cnt.sv
// sat_cnt: W-bit up-counter that holds at all-ones instead of wrapping.
//   Clk - clock, rising edge
//   Rst - asynchronous active-high reset, clears Q
//   Clr - synchronous clear, wins over Inc
//   Inc - increment request, ignored once Q is all-ones
//   Q   - current count
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Q
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Q <= '0;
    end else if (Clr) begin
      Q <= '0;
    end else if (Inc && (Q != '1)) begin
      Q <= Q + W'(1);
    end
  end

endmodule : sat_cnt

// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial-bit sequence detector.
// One bit of B is accepted per clock with En=1 and shifted into a history
// register; the newest LenR bits are compared against the loaded pattern.
// A registered one-cycle pulse on w flags each match, and a saturating
// counter records the number of matches since reset or the last Load.
//   Clk     - clock, rising edge
//   Rst     - asynchronous active-high reset
//   Load    - capture Pat/Len/Overlap and restart detection (beats En)
//   Pat     - pattern, Pat[Len-1] oldest bit, Pat[0] newest bit
//   Len     - pattern length, valid 1..PAT_W (otherwise detector idles)
//   Overlap - 1: matches may overlap; 0: history restarts after a match
//   En      - bit-accept strobe
//   B       - serial data bit
//   w       - match pulse, high the cycle after the final bit is accepted
//   Count   - saturating match count
//   Armed   - a valid pattern is loaded
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [PAT_W-1:0] Pat,
  input  logic [LEN_W-1:0] Len,
  input  logic             Overlap,
  input  logic             En,
  input  logic             B,
  output logic             w,
  output logic [CNT_W-1:0] Count,
  output logic             Armed
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic [PAT_W-1:0] h;
  logic [LEN_W-1:0] f;
  state_e           state;

  logic             accept;
  logic             hit;
  logic [PAT_W-1:0] h_next;
  logic [LEN_W-1:0] f_next;
  logic [PAT_W-1:0] mask;

  // NOTE: every signal written here gets a value on every pass through the
  // block, so no latch is inferred.
  always_comb begin
    accept = En && !Load && (state != IDLE);
    h_next = {h[PAT_W-2:0], B};
    f_next = f + ONE;
    // Low len_r bits set; a shift by PAT_W leaves all bits set.
    mask   = ~({PAT_W{1'b1}} << len_r);
    hit    = accept && (state == HUNT) && (((h_next ^ pat_r) & mask) == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pat_r <= '0;
      len_r <= '0;
      ovl_r <= 1'b0;
      h     <= '0;
      f     <= '0;
      state <= IDLE;
      w     <= 1'b0;
    end else begin
      // hit already excludes Load cycles, so w is 0 after a Load.
      w <= hit;
      if (Load) begin
        pat_r <= Pat;
        len_r <= Len;
        ovl_r <= Overlap;
        h     <= '0;
        f     <= '0;
        if ((Len == '0) || (Len > MAX_LEN)) begin
          state <= IDLE;
        end else if (Len == ONE) begin
          state <= HUNT;
        end else begin
          state <= FILL;
        end
      end else if (accept) begin
        h <= h_next;
        case (state)
          FILL: begin
            // After LenR-1 bits the next accepted bit completes a window.
            f <= f_next;
            if (f_next == (len_r - ONE)) begin
              state <= HUNT;
            end
          end
          HUNT: begin
            if (hit && !ovl_r) begin
              // Non-overlapping: the matched bits may not start a new match.
              h <= '0;
              f <= '0;
              if (len_r != ONE) begin
                state <= FILL;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .Clk(Clk),
    .Rst(Rst),
    .Clr(Load),
    .Inc(hit),
    .Q  (Count)
  );

  assign Armed = (state != IDLE);

endmodule : seq_det_prog

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: directed self-checking bench for seq_det_prog.
// Two instances share all inputs: dut (PAT_W=8, CNT_W=8) and dut_c2
// (PAT_W=8, CNT_W=2) for the counter saturation case.
module tb_seq_det_prog;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Load;
  logic [7:0] Pat;
  logic [3:0] Len;
  logic       Overlap;
  logic       En;
  logic       B;

  logic       w;
  logic [7:0] Count;
  logic       Armed;
  logic       w2;
  logic [1:0] count2;
  logic       armed2;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  seq_det_prog #(.PAT_W(8), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Load(Load), .Pat(Pat), .Len(Len),
    .Overlap(Overlap), .En(En), .B(B),
    .w(w), .Count(Count), .Armed(Armed)
  );

  seq_det_prog #(.PAT_W(8), .CNT_W(2)) dut_c2 (
    .Clk(Clk), .Rst(Rst), .Load(Load), .Pat(Pat), .Len(Len),
    .Overlap(Overlap), .En(En), .B(B),
    .w(w2), .Count(count2), .Armed(armed2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load cycle with En=1 and B=1 to show the bit is discarded.
  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
    Load = 1'b1; Pat = p; Len = l; Overlap = o; En = 1'b1; B = 1'b1;
    @(posedge Clk); #1;
    Load = 1'b0; En = 1'b0; B = 1'b0;
    check("w_after_load", w, 1'b0);
    check("count_after_load", Count, 8'd0);
  endtask

  // Accept one bit and check w in the cycle after the accepting edge.
  task automatic send(input logic b, input logic exp_w, input string tag);
    En = 1'b1; B = b;
    @(posedge Clk); #1;
    En = 1'b0;
    check(tag, w, exp_w);
  endtask

  task automatic stall(input int n);
    En = 1'b0;
    for (int i = 0; i < n; i++) begin
      B = 1'b1;
      @(posedge Clk); #1;
      check("w_stalled", w, 1'b0);
    end
  endtask

  initial begin
    Rst = 1'b1; Load = 1'b0; Pat = '0; Len = '0; Overlap = 1'b0; En = 1'b0; B = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_w", w, 1'b0);
    check("rst_count", Count, 8'd0);
    check("rst_armed", Armed, 1'b0);
    Rst = 1'b0;

    // IDLE ignores input.
    send(1'b1, 1'b0, "idle_w");
    check("idle_armed", Armed, 1'b0);

    // Pattern 110, non-overlap: match after the 0.
    do_load(8'b110, 4'd3, 1'b0);
    check("armed_110", Armed, 1'b1);
    send(1'b1, 1'b0, "p110_b1");
    send(1'b1, 1'b0, "p110_b2");
    send(1'b1, 1'b0, "p110_b3");
    send(1'b0, 1'b1, "p110_b4");
    check("p110_count", Count, 8'd1);
    stall(1);
    check("p110_count_hold", Count, 8'd1);

    // Pattern 101, overlapping: two matches.
    do_load(8'b101, 4'd3, 1'b1);
    send(1'b1, 1'b0, "ov_b1");
    send(1'b0, 1'b0, "ov_b2");
    send(1'b1, 1'b1, "ov_b3");
    send(1'b0, 1'b0, "ov_b4");
    send(1'b1, 1'b1, "ov_b5");
    check("ov_count", Count, 8'd2);

    // Pattern 101, non-overlapping: one match.
    do_load(8'b101, 4'd3, 1'b0);
    send(1'b1, 1'b0, "nov_b1");
    send(1'b0, 1'b0, "nov_b2");
    send(1'b1, 1'b1, "nov_b3");
    send(1'b0, 1'b0, "nov_b4");
    send(1'b1, 1'b0, "nov_b5");
    check("nov_count", Count, 8'd1);

    // Full-width 0xA5 with a 3-cycle En gap mid-stream.
    do_load(8'hA5, 4'd8, 1'b0);
    send(1'b1, 1'b0, "a5_b7");
    send(1'b0, 1'b0, "a5_b6");
    send(1'b1, 1'b0, "a5_b5");
    send(1'b0, 1'b0, "a5_b4");
    stall(3);
    send(1'b0, 1'b0, "a5_b3");
    send(1'b1, 1'b0, "a5_b2");
    send(1'b0, 1'b0, "a5_b1");
    send(1'b1, 1'b1, "a5_b0");
    check("a5_count", Count, 8'd1);

    // Invalid lengths leave the detector idle.
    do_load(8'h01, 4'd0, 1'b1);
    check("len0_armed", Armed, 1'b0);
    send(1'b1, 1'b0, "len0_b1");
    send(1'b0, 1'b0, "len0_b2");
    do_load(8'hFF, 4'd9, 1'b1);
    check("len9_armed", Armed, 1'b0);
    send(1'b1, 1'b0, "len9_b1");
    send(1'b1, 1'b0, "len9_b2");
    check("len9_count", Count, 8'd0);

    // Load mid-match discards the partial history.
    do_load(8'b110, 4'd3, 1'b0);
    send(1'b1, 1'b0, "mid_b1");
    send(1'b1, 1'b0, "mid_b2");
    do_load(8'b110, 4'd3, 1'b0);
    send(1'b0, 1'b0, "mid_b3");
    send(1'b1, 1'b0, "mid_r1");
    send(1'b1, 1'b0, "mid_r2");
    send(1'b0, 1'b1, "mid_r3");
    check("mid_count", Count, 8'd1);

    // Len=1 overlap, five ones: w every cycle, 2-bit counter saturates.
    do_load(8'h01, 4'd1, 1'b1);
    check("sat_armed", armed2, 1'b1);
    check("sat_c2_clr", count2, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      send(1'b1, 1'b1, "sat_w");
      check("sat_w2", w2, 1'b1);
      check("sat_count2", count2, (i > 3) ? 2'd3 : 2'(i));
      check("sat_count8", Count, 8'(i));
    end
    send(1'b0, 1'b0, "sat_zero");
    check("sat_count2_hold", count2, 2'd3);

    // Asynchronous reset while w is high in HUNT.
    do_load(8'b110, 4'd3, 1'b1);
    send(1'b1, 1'b0, "ar_b1");
    send(1'b1, 1'b0, "ar_b2");
    send(1'b0, 1'b1, "ar_b3");
    #2 Rst = 1'b1;
    #1;
    check("ar_w", w, 1'b0);
    check("ar_count", Count, 8'd0);
    check("ar_armed", Armed, 1'b0);
    check("ar_count2", count2, 2'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    send(1'b1, 1'b0, "ar_idle_w");
    check("ar_idle_armed", Armed, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_det_prog
